// File: rtl/mux_pkg.sv
// Shared definitions for the mux_arbiter slice: sel_mode encodings and clog2 helper.
package mux_pkg;

  typedef enum logic {
    MODE_ARB    = 1'b0,
    MODE_FORCED = 1'b1
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_grant.sv
// Combinational grant: forced select, or rotating priority search starting at i_ptr.
// With i_ptr tied to zero the search degenerates to plain fixed priority.
module mux_grant
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int SW  = clog2(NCH)
) (
  input  logic [NCH-1:0] i_valid,
  input  logic           i_mode,
  input  logic [SW-1:0]  i_sel,
  input  logic [SW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic           o_gnt_vld,
  output logic [SW-1:0]  o_idx
);

  logic [NCH-1:0] w_rot;
  int             w_sum;

  always_comb begin
    o_gnt_vld = 1'b0;
    o_idx     = '0;
    w_sum     = 0;
    w_rot     = NCH'({i_valid, i_valid} >> i_ptr);
    if (mode_e'(i_mode) == MODE_FORCED) begin
      // sel values at or above NCH never match a loop index, so they grant nothing
      for (int i = 0; i < NCH; i++)
        if (i_sel == SW'(i) && i_valid[i]) begin
          o_gnt_vld = 1'b1;
          o_idx     = SW'(i);
        end
    end else begin
      // descending scan: the lowest rotated position wins
      for (int j = NCH - 1; j >= 0; j--)
        if (w_rot[j]) begin
          o_gnt_vld = 1'b1;
          w_sum     = j + int'(i_ptr);
          if (w_sum >= NCH) w_sum = w_sum - NCH;
          o_idx     = SW'(w_sum);
        end
    end
    for (int i = 0; i < NCH; i++)
      o_gnt[i] = o_gnt_vld && (o_idx == SW'(i));
  end

endmodule

// File: rtl/mux_arbiter.sv
// NCH-to-1 registered mux with fixed-priority / forced-select arbitration.
// Define MUX_ARBITER_RR_EN to make arbitrated mode round-robin.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*WIDTH-1:0]    in_data,
  output logic [NCH-1:0]          in_ready,
  input  logic                    sel_mode,
  input  logic [clog2(NCH)-1:0]   sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [clog2(NCH)-1:0]   out_ch,
  input  logic                    out_ready
);

  localparam int SW = clog2(NCH);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_ch;

  logic [NCH-1:0]   w_gnt;
  logic             w_gnt_vld;
  logic [SW-1:0]    w_idx;
  logic [SW-1:0]    w_ptr;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

`ifdef MUX_ARBITER_RR_EN
  logic [SW-1:0] r_ptr;

  // forced transfers leave the rotation where it was
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_xfer && mode_e'(sel_mode) == MODE_ARB)
      r_ptr <= (w_idx == SW'(NCH - 1)) ? '0 : w_idx + 1'b1;
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  mux_grant #(.NCH(NCH), .SW(SW)) u_grant (
    .i_valid   (in_valid),
    .i_mode    (sel_mode),
    .i_sel     (sel),
    .i_ptr     (w_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_idx     (w_idx)
  );

  // rst_n gates ready so nothing is accepted while reset is held
  assign w_load   = (~r_out_valid | out_ready) & rst_n;
  assign w_xfer   = w_gnt_vld & w_load;
  assign in_ready = w_gnt & {NCH{w_load}};

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NCH; i++)
      if (w_idx == SW'(i)) w_data = in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  NCH  per-channel valid.
REQ-006 SHALL have port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_ready  output  NCH  per-channel ready.
REQ-008 SHALL have port sel_mode  input  1  0 = arbitrated, 1 = forced select.
REQ-009 SHALL have port sel  input  clog2(NCH)  channel index used when sel_mode=1.
REQ-010 SHALL have port out_valid  output  1  output register holds data.
REQ-011 SHALL have port out_data  output  WIDTH  registered data.
REQ-012 SHALL have port out_ch  output  clog2(NCH)  source channel of out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.

Function
REQ-014 SHALL define load = ~out_valid | out_ready; channel i transfers when in_valid[i] & in_ready[i].
REQ-015 SHALL assert at most one in_ready bit per cycle: in_ready[i] = grant[i] & load; grant is combinational, one-hot or zero.
REQ-016 SHALL in forced mode grant channel sel only if in_valid[sel]; sel >= NCH grants nothing.
REQ-017 SHALL in arbitrated mode grant the lowest-index valid channel (fixed priority) unless REQ-026 applies.
REQ-018 SHALL on a transfer load out_data/out_ch from the granted channel and set out_valid the next cycle (latency 1).
REQ-019 SHALL clear out_valid when out_ready=1 and no transfer occurs in the same cycle.
REQ-020 SHALL support full throughput: out_ready=1 plus a transfer in the same cycle replaces the entry, out_valid stays 1.
REQ-021 SHALL hold out_data/out_ch/out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL switch sel_mode/sel effective in the same cycle; no transfer is lost or duplicated.

Reset
REQ-023 SHALL on rst_n=0 immediately force out_valid=0, out_data=0, out_ch=0, round-robin pointer=0.
REQ-024 SHALL keep in_ready all-zero while rst_n=0; a transfer in progress at reset is discarded.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro MUX_ARBITER_RR_EN defined, use round-robin in arbitrated mode: search starts at pointer; after each arbitrated transfer from channel g, pointer = (g+1) mod NCH.
REQ-027 SHALL, without MUX_ARBITER_RR_EN, use fixed priority per REQ-017 and contain no pointer register.
REQ-028 SHALL leave the pointer unchanged by forced-mode transfers.

Structure
REQ-029 SHALL place the sel_mode encodings (MODE_ARB=0, MODE_FORCED=1) and a clog2 helper in shared package mux_pkg.
REQ-030 SHALL implement grant generation in one sub-module, mux_grant (fixed/round-robin, one-hot output plus index).

Verification
REQ-031 Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0 without a clock edge.
REQ-032 Fixed priority: in_valid=4'b1010, out_ready=1 -> in_ready=4'b0010, next cycle out_ch=1.
REQ-033 Round robin (MUX_ARBITER_RR_EN): in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0.
REQ-034 Forced: sel_mode=1, sel=2, in_valid=4'b0001 -> in_ready=0, out_valid stays 0; then in_valid[2]=1, data 32'hDEADBEEF -> next cycle out_data=32'hDEADBEEF, out_ch=2.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data unchanged; out_ready=1 -> next queued word appears one cycle later.
REQ-036 Throughput: continuous in_valid[0], out_ready=1 -> one word per cycle, no gaps, no duplicates.
